// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
// The fault rule is kept here so the decision is defined in one place.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} lsu_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Misaligned half/word accesses and unknown encodings never reach memory.
  function automatic logic access_fault(input logic write, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic f;
    f = 1'b1;
    if (write) begin
      case (f3)
        SB:      f = 1'b0;
        SH:      f = off[0];
        SW:      f = |off;
        default: f = 1'b1;
      endcase
    end else begin
      case (f3)
        LB, LBU: f = 1'b0;
        LH, LHU: f = off[0];
        LW:      f = |off;
        default: f = 1'b1;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a memory word and sign- or
// zero-extends it according to funct3; word loads pass straight through.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = word >> {byte_off, 3'b000};
    b       = shifted[7:0];
    h       = byte_off[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      result = {{24{b[7]}}, b};
      LH:      result = {{16{h[15]}}, h};
      LBU:     result = {24'b0, b};
      LHU:     result = {16'b0, h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the control unit and a
// synchronous-read word memory; fixed latency load 3, store 2, fault 1.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef struct packed {
    logic              write;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } lsu_req_t;

  lsu_state_t  state, state_nxt;
  lsu_req_t    req_q;
  logic        accept, req_fault;
  logic [31:0] ext;

  assign accept    = (state == IDLE) && req_valid;
  assign req_fault = access_fault(req_write, funct3, addr[1:0]);

  load_extend u_ext (
    .word     (mem_rdata),
    .byte_off (req_q.addr[1:0]),
    .funct3   (req_q.funct3),
    .result   (ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      req_q <= '0;
      fault <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q <= '{write: req_write, funct3: funct3, addr: addr, wdata: wdata};
        fault <= req_fault;
        if (req_fault) rdata <= '0;
      end
      if (state == CAPTURE) rdata <= ext;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_fault ? RESP : ACCESS;
      ACCESS:  state_nxt = req_q.write ? RESP : CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory bus is decoded from state so reset silences it without a clock edge.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    if (state == ACCESS) begin
      mem_addr = {req_q.addr[ADDR_W-1:2], 2'b00};
      mem_we   = req_q.write;
      mem_be   = 4'b1111;
      if (req_q.write) begin
        case (req_q.funct3)
          SB: begin
            mem_be    = 4'b0001 << req_q.addr[1:0];
            mem_wdata = {4{req_q.wdata[7:0]}};
          end
          SH: begin
            mem_be    = req_q.addr[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{req_q.wdata[15:0]}};
          end
          default: mem_wdata = req_q.wdata;
        endcase
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  access request from the control unit during its MEMORY state.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load; sampled with req_valid.
REQ-007 SHALL have port funct3  input  3  access size/sign (instr[14:12]); sampled with req_valid.
REQ-008 SHALL have port addr  input  ADDR_W  byte address (ALU result); sampled with req_valid.
REQ-009 SHALL have port wdata  input  DATA_W  store data (rs2); sampled with req_valid.
REQ-010 SHALL have port req_ready  output  1  high only in IDLE.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata  output  DATA_W  extended load result; held until the next completion.
REQ-013 SHALL have port fault  output  1  misaligned or illegal funct3; valid with rsp_valid and held until the next accept.
REQ-014 SHALL have port mem_addr  output  ADDR_W  word-aligned address, bits [1:0] always 0.
REQ-015 SHALL have port mem_we  output  1  memory write strobe.
REQ-016 SHALL have port mem_be  output  4  byte-lane enables.
REQ-017 SHALL have port mem_wdata  output  DATA_W  lane-replicated store data.
REQ-018 SHALL have port mem_rdata  input  DATA_W  memory read word, valid one cycle after mem_addr is presented.

Function
REQ-019 SHALL implement the FSM states IDLE, ACCESS, CAPTURE and RESP.
REQ-020 SHALL accept a request on any edge where the state is IDLE and req_valid=1, registering req_write, funct3, addr and wdata.
REQ-021 SHALL apply these transitions:
- IDLE -> ACCESS on a legal request.
- IDLE -> RESP on a faulting request.
- ACCESS -> CAPTURE on a load.
- ACCESS -> RESP on a store.
- CAPTURE -> RESP.
- RESP -> IDLE.
REQ-022 SHALL ignore req_valid outside IDLE, with no queueing.
REQ-023 SHALL drive mem_addr, mem_be and mem_we only in ACCESS; mem_we=1 only for a store, and mem_be=0 and mem_we=0 in every other state.
REQ-024 SHALL set store lanes as follows:
- SB: mem_be=0001<<addr[1:0], wdata[7:0] replicated into all four bytes.
- SH: mem_be=0011 if addr[1]=0, else 1100; wdata[15:0] replicated into both halves.
- SW: mem_be=1111.
REQ-025 SHALL drive mem_be=1111 for every load.
REQ-026 SHALL in CAPTURE select the byte or half of mem_rdata at addr[1:0] and sign-extend it (LB 000, LH 001) or zero-extend it (LBU 100, LHU 101); LW 010 passes the word unchanged; the result is registered into rdata.
REQ-027 SHALL treat these as faults:
- LH, LHU or SH with addr[0]=1.
- LW or SW with addr[1:0]!=00.
- funct3 not in {000,001,010,100,101} for loads.
- funct3 not in {000,001,010} for stores.
REQ-028 SHALL perform no memory access on a fault, set fault=1, load rdata=0 and pulse rsp_valid in RESP.
REQ-029 SHALL complete with fixed latency measured from the accept edge: load rsp_valid at edge +3, store at +2, fault at +1.
REQ-030 SHALL leave rdata unchanged on a store completion.

Reset
REQ-031 SHALL on reset=1, regardless of clk, force the state to IDLE and rdata=0, fault=0, rsp_valid=0, mem_we=0, mem_be=0, mem_addr=0 and mem_wdata=0.
REQ-032 SHALL abandon any in-flight access on reset, even mid-ACCESS, with no write completed and no rsp_valid; req_ready=1 from the first edge after reset deasserts.

Structure
REQ-033 SHALL place the state enum and the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) in shared package lsu_pkg.
REQ-034 SHALL put lane selection and extension in one combinational sub-module, load_extend, with inputs word, byte offset and funct3 and output the 32-bit result.

Verification
REQ-035 SHALL test this LB case: mem word 0x80FF_7F01 at 0x100, LB at addr 0x103 -> at +3 rdata=0xFFFF_FF80, fault=0.
REQ-036 SHALL test this LHU case: same word, LHU at 0x102 -> rdata=0x0000_80FF; LH at 0x102 -> rdata=0xFFFF_80FF.
REQ-037 SHALL test this SB case: SB wdata=0x1234_56AB at addr 0x201 -> in ACCESS mem_addr=0x200, mem_be=0010, mem_we=1, mem_wdata=0xABAB_ABAB; rsp_valid at +2.
REQ-038 SHALL test this fault case: LW at 0x102 -> fault=1, rdata=0, rsp_valid at +1, mem_we and mem_be stay 0 throughout.
REQ-039 SHALL test reset mid-operation: reset asserted while an SW is in ACCESS -> mem_we falls without waiting for a clock edge, no rsp_valid, req_ready=1 at the first edge after release.
REQ-040 SHALL test back-to-back requests: req_valid held high -> accepts occur only in IDLE, one per load every 4 cycles, with no missed or duplicate responses.
